// File: rtl/mod_cnt_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
// Direction/mode encodings match the up_dn and wrap_en pin levels.
package mod_cnt_pkg;

    // Widest counter the clamp helper supports
    localparam int MAX_W = 32;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b1;
    localparam logic MODE_SAT  = 1'b0;

    // Limit a load value to the programmed terminal value (unsigned, full width)
    function automatic logic [MAX_W-1:0] clamp_load(input logic [MAX_W-1:0] load_val,
                                                     input logic [MAX_W-1:0] max_val);
        logic [MAX_W-1:0] res;
        if (load_val > max_val) begin
            res = max_val;
        end else begin
            res = load_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable prescaler: counts enabled cycles 0..PRESCALE-1 and flags the
// enabled cycle on which the count sits at PRESCALE-1. Holds while enable = 0.
// Only built into mod_counter when MOD_CNT_PRESCALE_EN is defined.
module cnt_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic enable,
    output logic tick
);

    // PRESCALE = 1 still gets a 1-bit counter that simply stays at zero
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_r;

    // Prescale counter: cleared by reset or clr, wraps after the last enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {PW{1'b0}};
        end else if (clr) begin
            cnt_r <= {PW{1'b0}};
        end else if (enable) begin
            if (cnt_r == LAST) begin
                cnt_r <= {PW{1'b0}};
            end else begin
                cnt_r <= cnt_r + PW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = enable && (cnt_r == LAST);

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with programmable terminal value, synchronous load,
// wrap/saturate boundary handling, one-cycle terminal-count pulse and a
// sticky overflow flag. Optional feature macro: MOD_CNT_PRESCALE_EN
// (inserts cnt_prescaler so a step happens every PRESCALE enabled cycles).
module mod_counter
    import mod_cnt_pkg::*;
#(
    parameter int N        = 4,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] max_val,
    input  logic         wrap_en,
    input  logic         ovf_clr,
    output logic [N-1:0] out,
    output logic         tc,
    output logic         ovf
);

    // Reject unusable configurations at elaboration
    if ((N < 2) || (N > MAX_W) || (PRESCALE < 1)) begin : g_param_check
        $error("mod_counter: N must be 2..%0d and PRESCALE >= 1", MAX_W);
    end

    logic [N-1:0] out_r;
    logic [N-1:0] out_nxt_s;
    logic [N-1:0] load_clamp_s;
    logic         tc_r;
    logic         tc_nxt_s;
    logic         ovf_r;
    logic         ovf_nxt_s;
    logic         tick_s;
    logic         step_s;

`ifdef MOD_CNT_PRESCALE_EN
    // A load restarts the prescale period so the first step is a full period away
    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr    (load),
        .enable (enable),
        .tick   (tick_s)
    );
`else
    assign tick_s = enable;
`endif

    assign step_s       = enable && tick_s;
    assign load_clamp_s = N'(clamp_load(MAX_W'(load_val), MAX_W'(max_val)));

    // Next-state: load beats step; boundary events pulse tc and set ovf
    always_comb begin
        out_nxt_s = out_r;
        tc_nxt_s  = 1'b0;
        ovf_nxt_s = ovf_clr ? 1'b0 : ovf_r;
        if (load) begin
            out_nxt_s = load_clamp_s;
        end else if (step_s) begin
            if (up_dn == DIR_UP) begin
                // >= so that lowering max_val below out still hits the boundary
                if (out_r >= max_val) begin
                    tc_nxt_s  = 1'b1;
                    ovf_nxt_s = 1'b1;
                    if (wrap_en == MODE_WRAP) begin
                        out_nxt_s = {N{1'b0}};
                    end else begin
                        out_nxt_s = out_r;
                    end
                end else begin
                    out_nxt_s = out_r + N'(1);
                end
            end else begin
                // Down from above max_val just decrements; only zero is a boundary
                if (out_r == {N{1'b0}}) begin
                    tc_nxt_s  = 1'b1;
                    ovf_nxt_s = 1'b1;
                    if (wrap_en == MODE_WRAP) begin
                        out_nxt_s = max_val;
                    end else begin
                        out_nxt_s = out_r;
                    end
                end else begin
                    out_nxt_s = out_r - N'(1);
                end
            end
        end else begin
            out_nxt_s = out_r;
        end
    end

    // State registers for count, terminal-count pulse and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= {N{1'b0}};
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            out_r <= out_nxt_s;
            tc_r  <= tc_nxt_s;
            ovf_r <= ovf_nxt_s;
        end
    end

    assign out = out_r;
    assign tc  = tc_r;
    assign ovf = ovf_r;

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (N = 4).
// The prescaler scenario runs only when MOD_CNT_PRESCALE_EN is defined.
module tb_mod_counter;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         up_dn;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] max_val;
    logic         wrap_en;
    logic         ovf_clr;
    logic [N-1:0] out;
    logic         tc;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    mod_counter #(
        .N        (N),
        .PRESCALE (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .wrap_en  (wrap_en),
        .ovf_clr  (ovf_clr),
        .out      (out),
        .tc       (tc),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle before sampling
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; load = 1'b1; load_val = 4'd5;
        max_val = 4'd9; up_dn = 1'b1; wrap_en = 1'b1; ovf_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (out !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
                $display("FAIL reset[%0d] got out=%0d tc=%b ovf=%b exp out=0 tc=0 ovf=0", i, out, tc, ovf);
                bad++;
            end
        end
        rst = 1'b0; load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [N-1:0] e_out;
        logic         e_tc;
        logic         e_ovf;
        max_val = 4'd9; wrap_en = 1'b1; up_dn = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            e_out = (i <= 9) ? N'(i) : N'(i - 10);
            e_tc  = (i == 10);
            e_ovf = (i >= 10);
            total++;
            if (out !== e_out || tc !== e_tc || ovf !== e_ovf) begin
                $display("FAIL wrap_up[%0d] got out=%0d tc=%b ovf=%b exp out=%0d tc=%b ovf=%b",
                         i, out, tc, ovf, e_out, e_tc, e_ovf);
                bad++;
            end
        end
        enable = 1'b0;
        cyc();
        total++;
        if (out !== 4'd2 || tc !== 1'b0 || ovf !== 1'b1) begin
            $display("FAIL idle_hold got out=%0d tc=%b ovf=%b exp out=2 tc=0 ovf=1", out, tc, ovf);
            bad++;
        end
    endtask

    task automatic test_saturate();
        logic [N-1:0] up_out [4]  = '{4'd14, 4'd15, 4'd15, 4'd15};
        logic         up_tc  [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [N-1:0] dn_out [3]  = '{4'd1, 4'd0, 4'd0};
        logic         dn_tc  [3]  = '{1'b0, 1'b0, 1'b1};
        max_val = 4'd15; wrap_en = 1'b0;
        load = 1'b1; load_val = 4'd13; ovf_clr = 1'b1;
        cyc();
        load = 1'b0; ovf_clr = 1'b0;
        total++;
        if (out !== 4'd13 || tc !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL sat_load got out=%0d tc=%b ovf=%b exp out=13 tc=0 ovf=0", out, tc, ovf);
            bad++;
        end
        up_dn = 1'b1; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (out !== up_out[i] || tc !== up_tc[i] || ovf !== up_tc[i]) begin
                $display("FAIL sat_up[%0d] got out=%0d tc=%b ovf=%b exp out=%0d tc=%b ovf=%b",
                         i, out, tc, ovf, up_out[i], up_tc[i], up_tc[i]);
                bad++;
            end
        end
        enable = 1'b0; load = 1'b1; load_val = 4'd2;
        cyc();
        load = 1'b0; up_dn = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (out !== dn_out[i] || tc !== dn_tc[i]) begin
                $display("FAIL sat_dn[%0d] got out=%0d tc=%b exp out=%0d tc=%b",
                         i, out, tc, dn_out[i], dn_tc[i]);
                bad++;
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_load_clamp();
        max_val = 4'd7; up_dn = 1'b1; enable = 1'b1; wrap_en = 1'b1;
        load = 1'b1; load_val = 4'd12;
        cyc();
        total++;
        if (out !== 4'd7 || tc !== 1'b0) begin
            $display("FAIL clamp_hi got out=%0d tc=%b exp out=7 tc=0", out, tc);
            bad++;
        end
        load_val = 4'd5;
        cyc();
        total++;
        if (out !== 4'd5 || tc !== 1'b0) begin
            $display("FAIL load_wins got out=%0d tc=%b exp out=5 tc=0", out, tc);
            bad++;
        end
        load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_ovf_clr();
        max_val = 4'd7; wrap_en = 1'b1; up_dn = 1'b1;
        load = 1'b1; load_val = 4'd7;
        cyc();
        load = 1'b0; enable = 1'b1; ovf_clr = 1'b1;
        cyc();
        total++;
        if (out !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
            $display("FAIL ovf_clr_vs_event got out=%0d tc=%b ovf=%b exp out=0 tc=1 ovf=1", out, tc, ovf);
            bad++;
        end
        enable = 1'b0;
        cyc();
        ovf_clr = 1'b0;
        total++;
        if (out !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL ovf_clr_alone got out=%0d tc=%b ovf=%b exp out=0 tc=0 ovf=0", out, tc, ovf);
            bad++;
        end
    endtask

    task automatic test_max_lowered();
        wrap_en = 1'b1; max_val = 4'd15;
        load = 1'b1; load_val = 4'd10;
        cyc();
        load = 1'b0; max_val = 4'd4; up_dn = 1'b1; enable = 1'b1;
        cyc();
        total++;
        if (out !== 4'd0 || tc !== 1'b1) begin
            $display("FAIL lowered_up got out=%0d tc=%b exp out=0 tc=1", out, tc);
            bad++;
        end
        enable = 1'b0; max_val = 4'd15; load = 1'b1; load_val = 4'd10;
        cyc();
        load = 1'b0; max_val = 4'd4; up_dn = 1'b0; enable = 1'b1;
        cyc();
        total++;
        if (out !== 4'd9 || tc !== 1'b0) begin
            $display("FAIL lowered_dn got out=%0d tc=%b exp out=9 tc=0", out, tc);
            bad++;
        end
        enable = 1'b0;
    endtask

    task automatic test_max_zero();
        max_val = 4'd0; load = 1'b1; load_val = 4'd9;
        cyc();
        load = 1'b0;
        total++;
        if (out !== 4'd0) begin
            $display("FAIL zero_load got out=%0d exp out=0", out);
            bad++;
        end
        for (int i = 0; i < 3; i++) begin
            wrap_en = (i != 2);
            up_dn   = (i == 0);
            enable  = 1'b1;
            cyc();
            total++;
            if (out !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
                $display("FAIL zero_step[%0d] got out=%0d tc=%b ovf=%b exp out=0 tc=1 ovf=1", i, out, tc, ovf);
                bad++;
            end
        end
        enable = 1'b0;
    endtask

`ifdef MOD_CNT_PRESCALE_EN
    task automatic test_prescale();
        // enable pattern and expected out after each cycle (period 3)
        logic         en_v  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [N-1:0] exp_v [10] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2};
        max_val = 4'd15; wrap_en = 1'b1; up_dn = 1'b1;
        load = 1'b1; load_val = 4'd0; enable = 1'b0;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enable = en_v[i];
            cyc();
            total++;
            if (out !== exp_v[i] || tc !== 1'b0) begin
                $display("FAIL prescale[%0d] got out=%0d tc=%b exp out=%0d tc=0", i, out, tc, exp_v[i]);
                bad++;
            end
        end
        enable = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        max_val = 4'd0; wrap_en = 1'b1; ovf_clr = 1'b0;
        test_reset();
        test_wrap_up();
        test_saturate();
        test_load_clamp();
        test_ovf_clr();
        test_max_lowered();
        test_max_zero();
`ifdef MOD_CNT_PRESCALE_EN
        test_prescale();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
